// File: rtl/idelay_tap_mgr.sv
// Tap manager for IDELAY-style elements: load/inc/dec/read requests, settle wait, one response each.
// Define IDELAY_TAP_SHADOW_EN to keep per-channel shadow taps that are cross-checked against the element.
module idelay_tap_mgr #(
    parameter int  CH_NUM     = 4,
    parameter int  TAP_W      = 5,
    parameter int  SETTLE_CYC = 8,
    localparam int CH_W       = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ctrl_rdy,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [CH_W-1:0]         req_ch,
    input  logic [1:0]              req_op,
    input  logic [TAP_W-1:0]        req_val,
    output logic                    rsp_valid,
    output logic [TAP_W-1:0]        rsp_tap,
    output logic                    rsp_err,
    output logic [CH_NUM-1:0]       dly_ce,
    output logic [CH_NUM-1:0]       dly_inc,
    output logic [CH_NUM-1:0]       dly_ld,
    output logic [CH_NUM*TAP_W-1:0] dly_cntvaluein,
    input  logic [CH_NUM*TAP_W-1:0] dly_cntvalueout,
    output logic                    busy
);

    typedef enum logic [2:0] {WAIT_RDY, IDLE, ISSUE, SETTLE, RESP, ABORT} state_t;

    localparam logic [1:0]       OP_LOAD     = 2'b00;
    localparam logic [1:0]       OP_INC      = 2'b01;
    localparam logic [1:0]       OP_DEC      = 2'b10;
    localparam logic [1:0]       OP_READ     = 2'b11;
    localparam logic [TAP_W-1:0] TAP_MAX     = '1;
    localparam logic [TAP_W-1:0] TAP_ONE     = TAP_W'(1);
    localparam logic [7:0]       SETTLE_LAST = 8'(SETTLE_CYC - 1);

    state_t                  state;
    logic [CH_W-1:0]         ch_q;
    logic [7:0]              settle_cnt;
    logic [CH_NUM-1:0]       ce_q, inc_q, ld_q;

    logic [TAP_W-1:0]        req_tap_hw, sel_tap_hw, req_tap, sel_tap;
    logic                    req_in_range, req_err, req_mis, sel_mis;

    // Out-of-range channels read as tap 0; they are rejected before anything uses the value.
    function automatic logic [TAP_W-1:0] tap_of(input logic [CH_W-1:0] ch,
                                                 input logic [CH_NUM*TAP_W-1:0] bus);
        logic [TAP_W-1:0] t;
        t = '0;
        for (int k = 0; k < CH_NUM; k++)
            if (int'(ch) == k) t = bus[k*TAP_W +: TAP_W];
        return t;
    endfunction

    assign req_tap_hw = tap_of(req_ch, dly_cntvalueout);
    assign sel_tap_hw = tap_of(ch_q, dly_cntvalueout);

`ifdef IDELAY_TAP_SHADOW_EN
    logic [CH_NUM*TAP_W-1:0] shadow_q;
    logic [1:0]              op_q;
    logic [TAP_W-1:0]        val_q;
    assign req_tap = tap_of(req_ch, shadow_q);
    assign sel_tap = tap_of(ch_q, shadow_q);
`else
    assign req_tap = req_tap_hw;
    assign sel_tap = sel_tap_hw;
`endif

    assign req_mis      = (req_tap != req_tap_hw);
    assign sel_mis      = (sel_tap != sel_tap_hw);
    assign req_in_range = (int'(req_ch) < CH_NUM);
    assign req_err      = !req_in_range
                        || (req_op == OP_INC && req_tap == TAP_MAX)
                        || (req_op == OP_DEC && req_tap == '0);

    assign req_ready = (state == IDLE) && ctrl_rdy;
    assign busy      = (state != IDLE);

    // Losing calibration kills a pulse in the same cycle rather than at the next edge.
    assign dly_ce  = ce_q  & {CH_NUM{ctrl_rdy}};
    assign dly_inc = inc_q & {CH_NUM{ctrl_rdy}};
    assign dly_ld  = ld_q  & {CH_NUM{ctrl_rdy}};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= WAIT_RDY;
            ch_q           <= '0;
            settle_cnt     <= '0;
            ce_q           <= '0;
            inc_q          <= '0;
            ld_q           <= '0;
            rsp_valid      <= 1'b0;
            rsp_err        <= 1'b0;
            rsp_tap        <= '0;
            dly_cntvaluein <= '0;
`ifdef IDELAY_TAP_SHADOW_EN
            // NOTE: the shadow must mirror the element's reset tap, so it is reset despite being a per-channel array.
            shadow_q       <= '0;
            op_q           <= OP_LOAD;
            val_q          <= '0;
`endif
        end else begin
            // NOTE: pulses and rsp_valid default low here with non-blocking writes; later writes in this block win.
            ce_q      <= '0;
            inc_q     <= '0;
            ld_q      <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;

            case (state)
                WAIT_RDY: if (ctrl_rdy) state <= IDLE;

                IDLE: begin
                    if (!ctrl_rdy) begin
                        state <= WAIT_RDY;
                    end else if (req_valid) begin
                        ch_q <= req_ch;
`ifdef IDELAY_TAP_SHADOW_EN
                        op_q  <= req_op;
                        val_q <= req_val;
`endif
                        if (req_err || req_op == OP_READ) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= req_err || req_mis;
                            rsp_tap   <= req_tap;
                        end else begin
                            state <= ISSUE;
                            for (int k = 0; k < CH_NUM; k++) begin
                                if (int'(req_ch) == k) begin
                                    case (req_op)
                                        OP_LOAD: begin
                                            ld_q[k]                          <= 1'b1;
                                            dly_cntvaluein[k*TAP_W +: TAP_W] <= req_val;
                                        end
                                        OP_INC: begin
                                            ce_q[k]  <= 1'b1;
                                            inc_q[k] <= 1'b1;
                                        end
                                        default: ce_q[k] <= 1'b1;
                                    endcase
                                end
                            end
                        end
                    end
                end

                ISSUE: begin
                    if (!ctrl_rdy) begin
                        state     <= ABORT;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_tap   <= sel_tap;
                    end else begin
                        state      <= SETTLE;
                        settle_cnt <= SETTLE_LAST;
`ifdef IDELAY_TAP_SHADOW_EN
                        for (int k = 0; k < CH_NUM; k++) begin
                            if (int'(ch_q) == k) begin
                                case (op_q)
                                    OP_LOAD: shadow_q[k*TAP_W +: TAP_W] <= val_q;
                                    OP_INC:  shadow_q[k*TAP_W +: TAP_W] <= shadow_q[k*TAP_W +: TAP_W] + TAP_ONE;
                                    OP_DEC:  shadow_q[k*TAP_W +: TAP_W] <= shadow_q[k*TAP_W +: TAP_W] - TAP_ONE;
                                    default: ;
                                endcase
                            end
                        end
`endif
                    end
                end

                SETTLE: begin
                    if (!ctrl_rdy) begin
                        state     <= ABORT;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_tap   <= sel_tap;
                    end else if (settle_cnt == '0) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= sel_mis;
                        rsp_tap   <= sel_tap;
                    end else begin
                        settle_cnt <= settle_cnt - 8'd1;
                    end
                end

                RESP:    state <= IDLE;
                ABORT:   state <= WAIT_RDY;
                default: state <= WAIT_RDY;
            endcase
        end
    end

endmodule
